// File: rtl/hlink_tx_pkg.sv
// Shared definitions for the HLINK transmit side: datapath sizing and FSM state type.
package hlink_tx_pkg;

   localparam int IDATA_WIDTH = 8;
   localparam int MAC_NUM     = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/hlink_tx.sv
// HLINK transmit engine: streams a run of activation-cache words into the
// neighbour core's link register. The link has no backpressure, so grant gaps
// from the cache arbiter simply stretch the transfer; data is forwarded two
// cycles after each grant (one cycle cache latency, one output register).
module hlink_tx
   import hlink_tx_pkg::*;
#(
   parameter int CACHE_DATA_WIDTH = MAC_NUM * IDATA_WIDTH,
   parameter int ADDR_WIDTH       = 10,
   parameter int LEN_WIDTH        = 10
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [ADDR_WIDTH-1:0]       cmd_addr,
   input  logic [LEN_WIDTH-1:0]        cmd_len,
   input  logic                        abort,
   output logic                        cache_ren,
   output logic [ADDR_WIDTH-1:0]       cache_raddr,
   input  logic                        cache_gnt,
   input  logic [CACHE_DATA_WIDTH-1:0] cache_rdata,
   output logic [CACHE_DATA_WIDTH-1:0] hlink_wdata,
   output logic                        hlink_wen,
   output logic                        busy,
   output logic                        done
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [LEN_WIDTH-1:0]  rem;
   logic                  rd_pend;
   logic                  stop;

   // abort only matters once a transfer is underway; it also wins over a grant
   assign stop = abort && (state != ST_IDLE);

   // Sequencer: command capture, address/count stepping, read-pending tracking
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         cur_addr <= '0;
         rem      <= '0;
         rd_pend  <= 1'b0;
      end else if (stop) begin
         state    <= ST_IDLE;
         rd_pend  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               rd_pend <= 1'b0;
               if (cmd_valid) begin
                  cur_addr <= cmd_addr;
                  rem      <= cmd_len;
                  state    <= (cmd_len == '0) ? ST_DONE : ST_READ;
               end
            end
            ST_READ: begin
               if (cache_gnt) begin
                  cur_addr <= cur_addr + 1'b1;
                  rem      <= rem - 1'b1;
                  rd_pend  <= 1'b1;
                  if (rem == LEN_WIDTH'(1)) state <= ST_DRAIN;
               end else begin
                  rd_pend  <= 1'b0;
               end
            end
            ST_DRAIN: begin
               // final word's data is on cache_rdata now; rd_pend is high this cycle
               rd_pend <= 1'b0;
               state   <= ST_DONE;
            end
            default: begin
               rd_pend <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   // Output register: capture returning cache data and strobe the link
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hlink_wdata <= '0;
         hlink_wen   <= 1'b0;
      end else if (rd_pend && !stop) begin
         hlink_wdata <= cache_rdata;
         hlink_wen   <= 1'b1;
      end else begin
         hlink_wen   <= 1'b0;
      end
   end

   assign cmd_ready   = (state == ST_IDLE);
   assign busy        = (state != ST_IDLE);
   assign cache_ren   = (state == ST_READ) && !abort;
   assign cache_raddr = cur_addr;
   // the DONE cycle always carries the last hlink_wen, so done lines up with it
   assign done        = (state == ST_DONE) && !abort;

endmodule

// File: tb/tb_hlink_tx.sv
// Directed bench for hlink_tx: table of transfers with hand-derived timing,
// plus abort, mid-transfer reset and a loopback link register.
module tb_hlink_tx;

   localparam int DW = 128;
   localparam int AW = 10;
   localparam int LW = 10;
   localparam int NLOG = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          abort = 1'b0;
   logic          cache_ren;
   logic [AW-1:0] cache_raddr;
   logic          cache_gnt = 1'b0;
   logic [DW-1:0] cache_rdata = '0;
   logic [DW-1:0] hlink_wdata;
   logic          hlink_wen;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   hlink_tx #(.CACHE_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .abort(abort),
      .cache_ren(cache_ren), .cache_raddr(cache_raddr),
      .cache_gnt(cache_gnt), .cache_rdata(cache_rdata),
      .hlink_wdata(hlink_wdata), .hlink_wen(hlink_wen),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // cache content model: every word is derived from its address
   function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
      return {8{a, 6'h15}};
   endfunction

   // cache: one-cycle read latency on granted requests
   always @(posedge clk) begin
      if (cache_ren && cache_gnt) cache_rdata <= word_of(cache_raddr);
   end

   // downstream link register (loopback)
   logic          lr_v;
   logic [DW-1:0] lr_q;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lr_v <= 1'b0;
         lr_q <= '0;
      end else begin
         lr_v <= hlink_wen;
         if (hlink_wen) lr_q <= hlink_wdata;
      end
   end

   // per-cycle log of the current run, cycle 0 = command cycle
   logic          wen_log  [NLOG];
   logic [DW-1:0] data_log [NLOG];
   logic          ren_log  [NLOG];
   logic          gnt_log  [NLOG];
   logic [AW-1:0] raddr_log[NLOG];
   logic          done_log [NLOG];
   logic          busy_log [NLOG];
   logic          rdy_log  [NLOG];
   logic          lv_log   [NLOG];
   logic [DW-1:0] lq_log   [NLOG];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called just after a posedge with the DUT idle. gnt for cycle k is pat[k-1].
   task automatic run(input logic [AW-1:0] a, input logic [LW-1:0] l,
                      input logic [15:0] pat, input int abort_cyc, input int ncyc);
      cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cache_gnt = 1'b0; abort = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         if (k > 0) begin
            cmd_valid = 1'b0;
            cache_gnt = (k - 1 < 16) ? pat[k-1] : 1'b0;
            abort     = (k == abort_cyc);
         end
         @(negedge clk);
         wen_log[k] = hlink_wen;   data_log[k] = hlink_wdata;
         ren_log[k] = cache_ren;   gnt_log[k]  = cache_gnt;
         raddr_log[k] = cache_raddr;
         done_log[k] = done;       busy_log[k] = busy;
         rdy_log[k]  = cmd_ready;
         lv_log[k]   = lr_v;       lq_log[k]   = lr_q;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0; cache_gnt = 1'b0; abort = 1'b0;
   endtask

   // Verify a completed (non-aborted) run against its hand-derived timing
   task automatic check_vec(input string nm, input logic [AW-1:0] a, input logic [LW-1:0] l,
                            input int exp_nren, input int exp_done, input int ncyc);
      int nwords = 0, bad_data = 0, nren = 0, ngnt = 0, bad_addr = 0;
      int done_at = -1, ndone = 0, nbusy = 0, bad_lb = 0;
      logic [AW-1:0] ea;
      for (int k = 0; k < ncyc; k++) begin
         if (wen_log[k]) begin
            ea = a + AW'(nwords);
            if (data_log[k] !== word_of(ea)) bad_data++;
            nwords++;
         end
         if (ren_log[k]) begin
            nren++;
            if (gnt_log[k]) begin
               ea = a + AW'(ngnt);
               if (raddr_log[k] !== ea) bad_addr++;
               ngnt++;
            end
         end
         if (done_log[k]) begin
            if (done_at < 0) done_at = k;
            ndone++;
         end
         if (busy_log[k]) nbusy++;
         if (k > 0) begin
            if (lv_log[k] !== wen_log[k-1]) bad_lb++;
            else if (lv_log[k] && lq_log[k] !== data_log[k-1]) bad_lb++;
         end
      end
      chk({nm, " words"},     DW'(nwords),   DW'(l));
      chk({nm, " data"},      DW'(bad_data), '0);
      chk({nm, " nren"},      DW'(nren),     DW'(exp_nren));
      chk({nm, " raddr"},     DW'(bad_addr), '0);
      chk({nm, " done_at"},   DW'(done_at),  DW'(exp_done));
      chk({nm, " ndone"},     DW'(ndone),    DW'(1));
      chk({nm, " nbusy"},     DW'(nbusy),    DW'(exp_done));
      chk({nm, " rdy_after"}, DW'(rdy_log[exp_done+1]), DW'(1));
      chk({nm, " done_wen"},  DW'(wen_log[exp_done]),   DW'(l != '0));
      chk({nm, " loopback"},  DW'(bad_lb),   '0);
   endtask

   typedef struct {
      string         nm;
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
      logic [15:0]   pat;
      int            nren;
      int            done_cyc;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{"v_stream",  10'h010, 10'd4, 16'hFFFF, 4, 6};
      vecs[1] = '{"v_gaps",    10'h010, 10'd4, 16'h0059, 7, 9};
      vecs[2] = '{"v_zero",    10'h055, 10'd0, 16'hFFFF, 0, 1};
      vecs[3] = '{"v_wrap",    10'h3FE, 10'd4, 16'hFFFF, 4, 6};
      vecs[4] = '{"v_one",     10'h3FF, 10'd1, 16'h0002, 2, 4};
      vecs[5] = '{"v_lategnt", 10'h123, 10'd3, 16'h0038, 6, 8};

      // reset state
      #12;
      chk("rst cmd_ready", DW'(cmd_ready), DW'(1));
      chk("rst busy",      DW'(busy),      DW'(0));
      chk("rst done",      DW'(done),      DW'(0));
      chk("rst cache_ren", DW'(cache_ren), DW'(0));
      chk("rst hlink_wen", DW'(hlink_wen), DW'(0));
      chk("rst wdata",     hlink_wdata,    '0);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         run(vecs[i].addr, vecs[i].len, vecs[i].pat, -1, 20);
         check_vec(vecs[i].nm, vecs[i].addr, vecs[i].len, vecs[i].nren, vecs[i].done_cyc, 20);
      end

      // abort one cycle after the 2nd grant (grants in cycles 1,2; abort in 3)
      begin
         int nw = 0, nd = 0, nw_late = 0;
         run(10'h100, 10'd8, 16'hFFFF, 3, 10);
         for (int k = 0; k < 10; k++) begin
            if (wen_log[k]) nw++;
            if (wen_log[k] && k > 4) nw_late++;
            if (done_log[k]) nd++;
         end
         chk("abort ren_before",  DW'(ren_log[2]),  DW'(1));
         chk("abort ren_same",    DW'(ren_log[3]),  DW'(0));
         chk("abort nwen_range",  DW'(nw >= 1 && nw <= 2), DW'(1));
         chk("abort first_word",  data_log[3],      word_of(10'h100));
         chk("abort no_late_wen", DW'(nw_late),     DW'(0));
         chk("abort no_done",     DW'(nd),          DW'(0));
         chk("abort rdy_next",    DW'(rdy_log[4]),  DW'(1));
         chk("abort busy_next",   DW'(busy_log[4]), DW'(0));
      end
      run(10'h020, 10'd2, 16'hFFFF, -1, 12);
      check_vec("post_abort", 10'h020, 10'd2, 2, 4, 12);

      // reset pulse in the middle of a transfer
      run(10'h040, 10'd8, 16'hFFFF, -1, 3);
      cache_gnt = 1'b1;
      chk("pre_rst wen",  DW'(hlink_wen), DW'(1));
      rstn = 1'b0;
      #1;
      chk("mid_rst wen",   DW'(hlink_wen), DW'(0));
      chk("mid_rst ren",   DW'(cache_ren), DW'(0));
      chk("mid_rst busy",  DW'(busy),      DW'(0));
      chk("mid_rst done",  DW'(done),      DW'(0));
      chk("mid_rst ready", DW'(cmd_ready), DW'(1));
      cache_gnt = 1'b0;
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      run(10'h200, 10'd3, 16'hFFFF, -1, 12);
      check_vec("post_rst", 10'h200, 10'd3, 3, 5, 12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
